// File: rtl/cache_ctrl_if.sv
// CPU-port, cache and main-memory signal bundle for cache_ctrl.
// The controller attaches through the slave modport; the environment drives the master side.
interface cache_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              c_w_en;
    logic [ADDR_W-1:0] c_address;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req0, addr0, req1, we1, addr1, wdata1,
        input  c_rdata, c_hit, mem_rdata, mem_ready,
        output ack0, ack1, rdata, c_w_en, c_address, c_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, addr0, req1, we1, addr1, wdata1,
        output c_rdata, c_hit, mem_rdata, mem_ready,
        input  ack0, ack1, rdata, c_w_en, c_address, c_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl.sv
// Two-port cache sequencer: round-robin arbitration, hit lookup, read-miss refill,
// write-through without write-allocate.
module cache_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic         clk_1,
    input  logic         rst,
    cache_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        FILL,
        MEM_WR,
        CWRITE
    } state_t;

    state_t            state_q, state_d;
    logic              port_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic [DATA_W-1:0] fill_q;
    logic              last_grant_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata_q;

    logic              elig0, elig1;
    logic              do_grant, grant_port;
    logic              done;
    logic              load_rdata;
    logic [DATA_W-1:0] rdata_nxt;
    logic              capture_hit, capture_fill;

    // A port is skipped in its own ack cycle so a held req is not re-granted immediately.
    assign elig0 = bus.req0 & ~ack0_q;
    assign elig1 = bus.req1 & ~ack1_q;

    always_comb begin
        state_d       = state_q;
        do_grant      = 1'b0;
        grant_port    = 1'b0;
        done          = 1'b0;
        load_rdata    = 1'b0;
        rdata_nxt     = rdata_q;
        capture_hit   = 1'b0;
        capture_fill  = 1'b0;
        bus.c_w_en    = 1'b0;
        bus.c_wdata   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.c_address = (state_q == IDLE) ? '0 : addr_q;
        bus.mem_addr  = (state_q == IDLE) ? '0 : addr_q;

        case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    grant_port = ~last_grant_q;
                end else begin
                    grant_port = elig1;
                end
                do_grant = elig0 | elig1;
                if (do_grant) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    capture_hit = 1'b1;
                    state_d     = MEM_WR;
                end else if (bus.c_hit) begin
                    done       = 1'b1;
                    load_rdata = 1'b1;
                    rdata_nxt  = bus.c_rdata;
                    state_d    = IDLE;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    capture_fill = 1'b1;
                    state_d      = FILL;
                end
            end
            FILL: begin
                bus.c_w_en  = 1'b1;
                bus.c_wdata = fill_q;
                done        = 1'b1;
                load_rdata  = 1'b1;
                rdata_nxt   = fill_q;
                state_d     = IDLE;
            end
            MEM_WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = wdata_q;
                if (bus.mem_ready) begin
                    if (hit_q) begin
                        state_d = CWRITE;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            CWRITE: begin
                bus.c_w_en  = 1'b1;
                bus.c_wdata = wdata_q;
                done        = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            fill_q       <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            ack0_q  <= done & ~port_q;
            ack1_q  <= done & port_q;
            if (load_rdata) begin
                rdata_q <= rdata_nxt;
            end
            if (do_grant) begin
                port_q       <= grant_port;
                addr_q       <= grant_port ? bus.addr1 : bus.addr0;
                we_q         <= grant_port & bus.we1;
                wdata_q      <= bus.wdata1;
                last_grant_q <= grant_port;
            end
            if (capture_hit) begin
                hit_q <= bus.c_hit;
            end
            if (capture_fill) begin
                fill_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural cache and memory models, a vector table
// of single transactions, plus arbitration and reset-abort sequences.
module tb_cache_ctrl;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NE = 8;

    logic clk_1 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk_1 = ~clk_1;

    cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    cache_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk_1(clk_1), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic          cv [NE];
    logic [AW-1:0] ca [NE];
    logic [DW-1:0] cd [NE];

    int            mem_cyc, cw_cyc, bad_cyc, ack0_cnt, ack1_cnt, mcnt, mem_delay;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_wd, exp_cwd;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mdata;
        int            delay;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
        int            exp_mem;
        int            exp_cw;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int find(input logic [AW-1:0] a);
        for (int i = 0; i < NE; i++) begin
            if (cv[i] && ca[i] == a) return i;
        end
        return -1;
    endfunction

    task automatic cache_put(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int idx;
        idx = find(a);
        if (idx < 0) begin
            for (int i = 0; i < NE; i++) begin
                if (!cv[i] && idx < 0) idx = i;
            end
        end
        if (idx >= 0) begin
            cv[idx] = 1'b1;
            ca[idx] = a;
            cd[idx] = d;
        end
    endtask

    // One clock: observe DUT at the falling edge, then drive cache/memory responses.
    task automatic step();
        int idx;
        @(negedge clk_1);
        if (bus.mem_req) begin
            mem_cyc++;
            if (bus.mem_addr !== exp_addr || bus.mem_we !== exp_we ||
                (exp_we && bus.mem_wdata !== exp_wd)) bad_cyc++;
        end
        if (bus.c_w_en) begin
            cw_cyc++;
            if (bus.c_address !== exp_addr || bus.c_wdata !== exp_cwd) bad_cyc++;
            cache_put(bus.c_address, bus.c_wdata);
        end
        if (bus.ack0) ack0_cnt++;
        if (bus.ack1) ack1_cnt++;
        idx = find(bus.c_address);
        bus.c_hit   = (idx >= 0);
        bus.c_rdata = (idx >= 0) ? cd[idx] : 8'hEE;
        if (bus.mem_req) begin
            mcnt++;
            bus.mem_ready = (mcnt >= mem_delay);
        end else begin
            mcnt = 0;
            bus.mem_ready = 1'b0;
        end
        bus.mem_rdata = mem_data;
    endtask

    task automatic clear_counts();
        mem_cyc = 0; cw_cyc = 0; bad_cyc = 0; ack0_cnt = 0; ack1_cnt = 0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("v%0d", n);
        clear_counts();
        exp_addr = v.addr; exp_we = v.we; exp_wd = v.wdata;
        exp_cwd  = v.we ? v.wdata : v.mdata;
        mem_delay = v.delay; mem_data = v.mdata;
        if (v.port) begin
            bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
        end else begin
            bus.req0 = 1'b1; bus.addr0 = v.addr;
        end
        lat = 0;
        while (lat < 40 && !(bus.ack0 || bus.ack1)) begin
            step();
            lat++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " rdata"}, 64'(bus.rdata), 64'(v.exp_rdata));
        step(); step();
        check({tag, " ack0 count"}, 64'(ack0_cnt), v.port ? 64'd0 : 64'd1);
        check({tag, " ack1 count"}, 64'(ack1_cnt), v.port ? 64'd1 : 64'd0);
        check({tag, " mem_req cycles"}, 64'(mem_cyc), 64'(v.exp_mem));
        check({tag, " c_w_en cycles"}, 64'(cw_cyc), 64'(v.exp_cw));
        check({tag, " bus values"}, 64'(bad_cyc), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.ack0, bus.ack1, bus.rdata, bus.c_w_en, bus.c_address, bus.c_wdata,
                    bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata});
    endfunction

    initial begin
        int t_ack [4];
        int p_ack [4];
        logic [DW-1:0] d_ack [4];
        int na, cyc, both;

        //            port we  addr      wdata  mdata  dly rdata  lat mem cw
        vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 1, 8'hA5, 2, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 16'h0040, 8'h00, 8'h3C, 3, 8'h3C, 6, 3, 1};
        vecs[2] = '{1'b1, 1'b0, 16'h0040, 8'h00, 8'h00, 1, 8'h3C, 2, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 16'h00FF, 8'h77, 8'h00, 2, 8'h3C, 5, 2, 1};
        vecs[4] = '{1'b1, 1'b1, 16'h0100, 8'h11, 8'h00, 2, 8'h3C, 4, 2, 0};
        vecs[5] = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h5A, 1, 8'h5A, 4, 1, 1};
        vecs[6] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h00, 1, 8'h77, 2, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'h00, 1, 8'hA5, 2, 0, 0};

        for (int i = 0; i < NE; i++) begin
            cv[i] = 1'b0; ca[i] = '0; cd[i] = '0;
        end
        cache_put(16'h1234, 8'hA5);
        cache_put(16'h00FF, 8'h20);
        cache_put(16'h1000, 8'hB1);
        cache_put(16'h2000, 8'hC2);

        bus.req0 = 1'b0; bus.addr0 = '0; bus.req1 = 1'b0; bus.we1 = 1'b0;
        bus.addr1 = '0; bus.wdata1 = '0; bus.c_rdata = '0; bus.c_hit = 1'b0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        mcnt = 0; mem_delay = 1; mem_data = '0;
        exp_addr = '0; exp_we = 1'b0; exp_wd = '0; exp_cwd = '0;
        clear_counts();

        rst = 1'b1;
        step(); step(); step();
        check("reset outputs", all_outs(), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Both ports held: alternate 0,1,0,1 with a two-cycle spacing between acks.
        do_reset();
        clear_counts();
        exp_addr = '0;
        bus.req0 = 1'b1; bus.addr0 = 16'h1000;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h2000;
        na = 0; cyc = 0; both = 0;
        while (na < 4 && cyc < 60) begin
            step();
            cyc++;
            if (bus.ack0 && bus.ack1) both++;
            if (bus.ack0 || bus.ack1) begin
                t_ack[na] = cyc; p_ack[na] = bus.ack1 ? 1 : 0; d_ack[na] = bus.rdata;
                na++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("rr ack count", 64'(na), 64'd4);
        check("rr simultaneous acks", 64'(both), 64'd0);
        for (int k = 0; k < na; k++) begin
            check($sformatf("rr port %0d", k), 64'(p_ack[k]), 64'(k % 2));
            check($sformatf("rr rdata %0d", k), 64'(d_ack[k]), (k % 2) ? 64'hC2 : 64'hB1);
            check($sformatf("rr cycle %0d", k), 64'(t_ack[k]), 64'(2 + 2 * k));
        end
        step(); step();

        // Reset in the middle of a refill aborts without an ack.
        clear_counts();
        exp_addr = 16'h3000; exp_we = 1'b0; mem_delay = 20; mem_data = 8'h99;
        bus.req0 = 1'b1; bus.addr0 = 16'h3000;
        step(); step();
        check("abort mem_req before reset", 64'(bus.mem_req), 64'd1);
        rst = 1'b1;
        step();
        check("abort outputs after reset", all_outs(), 64'd0);
        rst = 1'b0;
        bus.req0 = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("abort no ack0", 64'(ack0_cnt), 64'd0);
        check("abort no ack1", 64'(ack1_cnt), 64'd0);
        check("abort no fill", 64'(cw_cyc), 64'd0);
        run_vec(8, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
